apb_bytemem_slave: RTL and testbench
====================================

Name: apb_bytemem_slave

Overview:
- Parametrised APB slave with an internal byte-addressed memory. It is the next generation of the address/strobe decoder: it generalises data width and memory depth and adds byte-lane writes with unaligned addressing.
- Adds range-error detection for full transfers, configurable wait states, PSLVERR signalling and a saturating error counter.
- Sits behind the APB interconnect as a scratch/config memory target.

Parameters:
DataWidth, 32, APB data width in bits; legal values 8, 16, 32; NB = DataWidth/8 byte lanes.
NumBytes, 256, memory size in bytes; power of two, >= NB; AW = $clog2(NumBytes).
WaitStates, 0, number of access cycles with pready low before completion; range 0..15.
ErrCntWidth, 8, width of the saturating error counter.

Ports:
pclk  input  1  clock; all logic on rising edge.
presetn  input  1  synchronous, active-low reset.
psel  input  1  slave select.
penable  input  1  access phase indicator.
pwrite  input  1  1 = write, 0 = read.
paddr  input  32  byte address; unaligned addresses are allowed.
pwdata  input  DataWidth  write data; lane i = pwdata[8i+7:8i].
pstrb  input  NB  byte-lane write strobes.
prdata  output  DataWidth  read data; valid only while pready=1.
pready  output  1  transfer completion; registered.
pslverr  output  1  transfer error; valid only while pready=1, otherwise 0.
err_count  output  ErrCntWidth  count of errored transfers; saturates at all-ones.

Behaviour:
- Reset (presetn=0 at a rising edge): FSM goes to IDLE; prdata=0, pready=0, pslverr=0, err_count=0. Memory contents are not reset.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on psel=1 & penable=0 (setup cycle). At that edge: latch paddr/pwrite/pstrb/pwdata, compute error, load wait counter with WaitStates, set pready_r = (WaitStates==0).
  - ACCESS with psel=1 & penable=1 & pready=0: decrement the counter; set pready_r when the counter reaches 1.
  - ACCESS with psel & penable & pready: transfer completes at this edge. Write commits here. Go to IDLE and clear pready, prdata and pslverr.
  - ACCESS with psel=0: abort. Go to IDLE, no memory write, err_count unchanged.
  - IDLE with penable=1 and no setup: ignored; pready stays 0.
- Latency:
  - The transfer completes in access cycle WaitStates+1.
  - WaitStates=0 gives the standard 2-cycle APB transfer (setup + one access).
- Back-to-back transfers: a new setup is accepted in the cycle after completion.
- Address and error rules (all arithmetic on AW+1 bits):
  - hi = index of the highest set pstrb bit for writes, NB-1 for reads.
  - ref = {1'b0, paddr[AW-1:0]} + hi.
  - Error if ref[AW]=1 (the transfer runs past the end of memory) or if paddr[31:AW] != 0.
  - There is no wrap-around.
- Write without error: for each lane i with pstrb[i]=1, mem[paddr+i] <= pwdata lane i. Lanes with pstrb[i]=0 are untouched. pstrb=0 is a legal no-op write.
- Write with error: no byte is written, including lanes that would be in range.
- Read without error: prdata lane i = mem[paddr+i], sampled so that it is presented with pready.
- Read with error: prdata=0. pstrb is ignored on reads.
- pslverr = error, driven only while pready=1. err_count increments by 1 at each completing edge with error and holds at max.
- Reset mid-transfer: the transfer is dropped, no write commits, and all outputs return to reset values next cycle.
- Illegal parameter values stop elaboration via assertion.

Test Plan:
1. Use DataWidth=32, NumBytes=64, WaitStates=2 for all scenarios. Write paddr=0x04, pstrb=4'hF, pwdata=0xDEADBEEF, then read 0x04 -> prdata=0xDEADBEEF. pready is high only in the 3rd access cycle of each transfer; pslverr=0.
2. Write paddr=0x10, pstrb=4'b0010, pwdata=0x0000AB00 after 0x10 holds 0x11223344 -> a read of 0x10 returns 0x1122AB44.
3. Unaligned write paddr=0x3D, pstrb=4'b0111, pwdata=0x00CCBBAA -> no error; bytes 0x3D..0x3F = AA,BB,CC. Same address with pstrb=4'b1000 -> pslverr=1, no bytes changed, err_count=1.
4. Read paddr=0x3E -> pslverr=1, prdata=0. Read paddr=0x100 (upper bits set) -> pslverr=1; err_count increments each time.
5. Start a write to 0x20; drop presetn in the 2nd access cycle -> pready, pslverr and err_count are 0. A later read of 0x20 shows the old contents.
6. Setup then psel=0 mid-access -> FSM returns to IDLE, no write. Hit the error condition 256 times with ErrCntWidth=8 -> err_count holds at 0xFF.

Source files
------------

// File: rtl/apb_bytemem_slave.sv
// APB slave fronting a byte-addressed scratch memory with byte-lane writes,
// unaligned addressing, range-error detection, wait states and an error counter.
module apb_bytemem_slave #(
    parameter int DataWidth   = 32,
    parameter int NumBytes    = 256,
    parameter int WaitStates  = 0,
    parameter int ErrCntWidth = 8
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [31:0]              paddr,
    input  logic [DataWidth-1:0]     pwdata,
    input  logic [DataWidth/8-1:0]   pstrb,
    output logic [DataWidth-1:0]     prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [ErrCntWidth-1:0]   err_count
);

    localparam int NB = DataWidth / 8;
    localparam int AW = $clog2(NumBytes);

    if (!(DataWidth == 8 || DataWidth == 16 || DataWidth == 32)) begin : g_bad_dw
        $error("apb_bytemem_slave: DataWidth must be 8, 16 or 32");
    end
    if (NumBytes < NB || (NumBytes & (NumBytes - 1)) != 0 || AW >= 32) begin : g_bad_nb
        $error("apb_bytemem_slave: NumBytes must be a power of two, >= NB and < 2**32");
    end
    if (WaitStates < 0 || WaitStates > 15) begin : g_bad_ws
        $error("apb_bytemem_slave: WaitStates must be in 0..15");
    end
    if (ErrCntWidth < 1) begin : g_bad_ecw
        $error("apb_bytemem_slave: ErrCntWidth must be at least 1");
    end

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Offset of the last byte touched: highest strobed lane for writes, full word for reads.
    function automatic logic [AW:0] top_offset(input logic wr, input logic [NB-1:0] strb);
        logic [AW:0] hi;
        if (wr) begin
            hi = '0;
            for (int i = 0; i < NB; i++) begin
                hi = strb[i] ? (AW+1)'(i) : hi;
            end
        end else begin
            hi = (AW+1)'(NB - 1);
        end
        return hi;
    endfunction

    // No wrap-around: any byte past the end, or any upper address bit, is an error.
    function automatic logic range_err(input logic [31:0] addr, input logic wr,
                                       input logic [NB-1:0] strb);
        logic [AW:0] last;
        last = {1'b0, addr[AW-1:0]} + top_offset(wr, strb);
        return last[AW] || (addr[31:AW] != '0);
    endfunction

    logic [7:0]             mem_q [NumBytes];

    state_e                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic                   write_q, write_d;
    logic [NB-1:0]          strb_q, strb_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DataWidth-1:0]   prdata_q, prdata_d;
    logic [ErrCntWidth-1:0] errcnt_q, errcnt_d;

    logic                   setup_err_s;
    logic [AW-1:0]          rd_addr_s;
    logic [DataWidth-1:0]   rd_data_s;
    logic                   mem_we_s;

    assign setup_err_s = range_err(paddr, pwrite, pstrb);

    // Read port follows the bus address in IDLE so zero-wait reads return data with pready.
    always_comb begin
        rd_addr_s = (state_q == IDLE) ? paddr[AW-1:0] : addr_q;
        rd_data_s = '0;
        for (int i = 0; i < NB; i++) begin
            rd_data_s[8*i +: 8] = mem_q[rd_addr_s + AW'(i)];
        end
    end

    // Next-state and output logic of the transfer FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        errcnt_d  = errcnt_q;
        mem_we_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    addr_d  = paddr[AW-1:0];
                    write_d = pwrite;
                    strb_d  = pstrb;
                    wdata_d = pwdata;
                    err_d   = setup_err_s;
                    cnt_d   = 4'(WaitStates);
                    if (WaitStates == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err_s;
                        prdata_d  = (!pwrite && !setup_err_s) ? rd_data_s : '0;
                    end else begin
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end else begin
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (penable && pready_q) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                    mem_we_s  = write_q && !err_q;
                    if (err_q && !(&errcnt_q)) begin
                        errcnt_d = errcnt_q + ErrCntWidth'(1);
                    end else begin
                        errcnt_d = errcnt_q;
                    end
                end else if (penable) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (!write_q && !err_q) ? rd_data_s : '0;
                    end else begin
                        pready_d  = 1'b0;
                    end
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    // FSM, latched transfer and output registers with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            errcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            errcnt_q  <= errcnt_d;
        end
    end

    // Byte-lane memory writes; contents survive reset, and a reset at the commit edge drops the write.
    always_ff @(posedge pclk) begin
        if (presetn && mem_we_s) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) begin
                    mem_q[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign prdata    = prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign err_count = errcnt_q;

endmodule

// File: tb/tb_apb_bytemem_slave.sv
// Directed bench for apb_bytemem_slave (32-bit, 64 bytes, two wait states) with an expectation queue.
module tb_apb_bytemem_slave;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  err_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb_q [$];

    apb_bytemem_slave #(
        .DataWidth  (32),
        .NumBytes   (64),
        .WaitStates (2),
        .ErrCntWidth(8)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .err_count(err_count)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Full APB transfer; the expectation is queued at setup and checked when pready rises.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        exp_t e;
        sb_q.push_back('{wr: wr, rd: exp_rd, err: exp_err});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pstrb = strb; pwdata = wd;
        tick();
        penable = 1'b1;
        n = 1;
        while (pready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
            if (!e.wr) begin
                chk({tag, "_prdata"}, prdata, e.rd);
            end
        end
        tick();
        psel = 1'b0; penable = 1'b0;
        chk({tag, "_pready_clr"}, {31'd0, pready}, 32'd0);
    endtask

    initial begin
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0;
        repeat (3) tick();
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        presetn = 1'b1;
        tick();

        // Stray penable without setup is ignored.
        penable = 1'b1;
        tick();
        chk("stray_penable", {31'd0, pready}, 32'd0);
        penable = 1'b0;

        xfer("t1_wr", 1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0);
        xfer("t1_rd", 1'b0, 32'h04, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);

        xfer("t2_wr_full", 1'b1, 32'h10, 4'hF, 32'h11223344, 32'd0, 1'b0);
        xfer("t2_wr_lane1", 1'b1, 32'h10, 4'b0010, 32'h0000AB00, 32'd0, 1'b0);
        xfer("t2_rd", 1'b0, 32'h10, 4'h0, 32'd0, 32'h1122AB44, 1'b0);

        xfer("t3_init", 1'b1, 32'h3C, 4'hF, 32'h99887766, 32'd0, 1'b0);
        xfer("t3_unal_wr", 1'b1, 32'h3D, 4'b0111, 32'h00CCBBAA, 32'd0, 1'b0);
        chk("t3_errcnt0", {24'd0, err_count}, 32'd0);
        xfer("t3_rd", 1'b0, 32'h3C, 4'h0, 32'd0, 32'hCCBBAA66, 1'b0);
        xfer("t3_err_wr", 1'b1, 32'h3D, 4'b1000, 32'h55555555, 32'd0, 1'b1);
        chk("t3_errcnt1", {24'd0, err_count}, 32'd1);
        xfer("t3_rd_after", 1'b0, 32'h3C, 4'h0, 32'd0, 32'hCCBBAA66, 1'b0);

        xfer("t4_rd_3e", 1'b0, 32'h3E, 4'h1, 32'd0, 32'd0, 1'b1);
        chk("t4_errcnt2", {24'd0, err_count}, 32'd2);
        xfer("t4_rd_100", 1'b0, 32'h100, 4'h0, 32'd0, 32'd0, 1'b1);
        chk("t4_errcnt3", {24'd0, err_count}, 32'd3);

        // Reset during the second access cycle of a write drops it.
        xfer("t5_init", 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pstrb = 4'hF;
        pwdata = 32'h12345678;
        tick();
        penable = 1'b1;
        tick();
        presetn = 1'b0;
        tick();
        chk("t5_pready", {31'd0, pready}, 32'd0);
        chk("t5_pslverr", {31'd0, pslverr}, 32'd0);
        chk("t5_errcnt", {24'd0, err_count}, 32'd0);
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        tick();
        tick();
        xfer("t5_rd", 1'b0, 32'h20, 4'h0, 32'd0, 32'hCAFEF00D, 1'b0);

        // Abort a valid write and an erroring write by dropping psel mid-access.
        xfer("t6_init", 1'b1, 32'h30, 4'hF, 32'h01020304, 32'd0, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pstrb = 4'hF;
        pwdata = 32'hFFFFFFFF;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        chk("t6_abort_pready", {31'd0, pready}, 32'd0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h100;
        tick();
        penable = 1'b1;
        tick();
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        chk("t6_abort_errcnt", {24'd0, err_count}, 32'd0);
        xfer("t6_rd", 1'b0, 32'h30, 4'h0, 32'd0, 32'h01020304, 1'b0);

        for (int i = 1; i <= 256; i++) begin
            xfer("t6_sat", 1'b0, 32'h100, 4'h0, 32'd0, 32'd0, 1'b1);
            if (i == 254) begin
                chk("t6_errcnt_254", {24'd0, err_count}, 32'h0FE);
            end
        end
        chk("t6_errcnt_sat", {24'd0, err_count}, 32'h0FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
